// File: rtl/axi_typedef_pkg.sv
// Shared AXI field types and response codes, plus the FSM state encodings
// used by the default-slave responder.
package axi_typedef_pkg;

   typedef logic [7:0] len_t;   // AxLEN: burst length minus one
   typedef logic [1:0] resp_t;  // xRESP

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DRAIN,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_BURST
   } r_state_e;

endpackage

// File: rtl/axi_sync_fifo.sv
// Small synchronous FIFO for queued request descriptors.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i  enqueue (ignored while full)
//   pop_i, data_o   dequeue; data_o shows the head entry whenever !empty_o
//   full_o, empty_o occupancy flags
module axi_sync_fifo #(
   parameter int  Depth  = 4,
   parameter type data_t = logic
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  data_t data_i,
   input  logic  pop_i,
   output data_t data_o,
   output logic  full_o,
   output logic  empty_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   typedef logic [PtrW-1:0] ptr_t;

   data_t mem [Depth];
   ptr_t  wr_ptr_q, rd_ptr_q;
   // Wrap bits flip each time a pointer passes the end; equal pointers with
   // differing wrap bits means full, matching wrap bits means empty.
   logic  wr_wrap_q, rd_wrap_q;
   logic  do_push, do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign empty_o = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
   assign full_o  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         wr_wrap_q <= 1'b0;
         rd_wrap_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (wr_ptr_q == ptr_t'(Depth - 1)) wr_wrap_q <= ~wr_wrap_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (rd_ptr_q == ptr_t'(Depth - 1)) rd_wrap_q <= ~rd_wrap_q;
         end
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/axi_err_slv.sv
// Default AXI slave: terminates every request that decoded to no real target.
// All AW/AR requests are accepted into small FIFOs, write data is drained
// until w_last, and every transaction is answered with a fixed error response
// (one B beat per write, len+1 R beats per read) in request order.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   aw_* / w_* / b_*              write address, data, response channels
//   ar_* / r_*                    read address and data channels
module axi_err_slv
   import axi_typedef_pkg::*;
#(
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned MaxTrans     = 4,
   parameter resp_t       Resp         = RESP_DECERR,
   parameter logic [63:0] RespData     = 64'hCA11_AB1E_BADC_AB1E
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [AxiIdWidth-1:0]   aw_id_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  logic                    w_last_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output logic [AxiIdWidth-1:0]   b_id_o,
   output resp_t                   b_resp_o,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   input  logic [AxiIdWidth-1:0]   ar_id_i,
   input  len_t                    ar_len_i,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic [AxiIdWidth-1:0]   r_id_o,
   output logic [AxiDataWidth-1:0] r_data_o,
   output resp_t                   r_resp_o,
   output logic                    r_last_o
);

   typedef logic [AxiIdWidth-1:0] id_t;
   typedef struct packed {
      id_t  id;
      len_t len;
   } ar_entry_t;

   localparam logic [AxiDataWidth-1:0] RData = AxiDataWidth'(RespData);

   // ---------------- write path ----------------
   id_t      aw_head_id, b_id_q;
   logic     aw_full, aw_empty, aw_push, aw_pop;
   w_state_e w_state_q, w_state_d;

   assign aw_ready_o = !aw_full && !rst_i;
   assign aw_push    = aw_valid_i && aw_ready_o;
   assign b_resp_o   = Resp;

   axi_sync_fifo #(.Depth(MaxTrans), .data_t(id_t)) i_aw_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (aw_push),
      .data_i  (aw_id_i),
      .pop_i   (aw_pop),
      .data_o  (aw_head_id),
      .full_o  (aw_full),
      .empty_o (aw_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         b_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         if (w_state_q == W_DRAIN && w_valid_i && w_last_i) b_id_q <= aw_head_id;
      end
   end

   // A same-cycle AW push counts as non-empty so the drain can start the
   // very next cycle instead of one later.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (!aw_empty || aw_push) w_state_d = W_DRAIN;
         W_DRAIN: if (w_valid_i && w_last_i) w_state_d = W_RESP;
         W_RESP:  if (b_ready_i) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      w_ready_o = 1'b0;
      b_valid_o = 1'b0;
      b_id_o    = '0;
      aw_pop    = 1'b0;
      case (w_state_q)
         W_DRAIN: w_ready_o = !rst_i;
         W_RESP: begin
            b_valid_o = !rst_i;
            b_id_o    = b_id_q;
            aw_pop    = b_ready_i && !rst_i;
         end
         default: ;
      endcase
   end

   // ---------------- read path ----------------
   ar_entry_t ar_in, ar_head;
   logic      ar_full, ar_empty, ar_push, ar_pop;
   r_state_e  r_state_q, r_state_d;
   len_t      beat_cnt_q;

   assign ar_ready_o = !ar_full && !rst_i;
   assign ar_push    = ar_valid_i && ar_ready_o;
   assign ar_in      = {ar_id_i, ar_len_i};
   assign r_resp_o   = Resp;

   axi_sync_fifo #(.Depth(MaxTrans), .data_t(ar_entry_t)) i_ar_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (ar_push),
      .data_i  (ar_in),
      .pop_i   (ar_pop),
      .data_o  (ar_head),
      .full_o  (ar_full),
      .empty_o (ar_empty)
   );

   // beat_cnt counts remaining beats after the current one; it is reloaded
   // every idle cycle, from the bypassed request when the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q  <= R_IDLE;
         beat_cnt_q <= '0;
      end else begin
         r_state_q <= r_state_d;
         if (r_state_q == R_IDLE)
            beat_cnt_q <= ar_empty ? ar_len_i : ar_head.len;
         else if (r_ready_i && beat_cnt_q != '0)
            beat_cnt_q <= beat_cnt_q - len_t'(1);
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (!ar_empty || ar_push) r_state_d = R_BURST;
         R_BURST: if (r_ready_i && beat_cnt_q == '0) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      r_valid_o = 1'b0;
      r_id_o    = '0;
      r_data_o  = '0;
      r_last_o  = 1'b0;
      ar_pop    = 1'b0;
      if (r_state_q == R_BURST) begin
         r_valid_o = !rst_i;
         r_id_o    = ar_head.id;
         r_data_o  = RData;
         r_last_o  = (beat_cnt_q == '0);
         ar_pop    = r_ready_i && r_last_o && !rst_i;
      end
   end

endmodule

// File: tb/tb_axi_err_slv.sv
module tb_axi_err_slv;

   localparam int MT = 4;
   localparam logic [63:0] EXP_DATA = 64'hCA11AB1EBADCAB1E;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i;
   logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
   logic        r_valid_o, r_ready_i, r_last_o;
   logic [3:0]  aw_id_i, b_id_o, ar_id_i, r_id_o;
   logic [7:0]  ar_len_i;
   logic [1:0]  b_resp_o, r_resp_o;
   logic [63:0] r_data_o;

   always #5 clk_i = ~clk_i;

   axi_err_slv #(.AxiIdWidth(4), .AxiDataWidth(64), .MaxTrans(MT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
      .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
      .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
      .r_resp_o(r_resp_o), .r_last_o(r_last_o)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // ---------------- behavioural model ----------------
   // Each transaction is a queue entry with its acceptance cycle. A response
   // phase opens one cycle after acceptance, but never earlier than two cycles
   // after the previous transaction on that channel completed.
   int cyc = 0;
   int aw_q[$], awt_q[$];
   int ar_id_q[$], ar_len_q[$], art_q[$];
   bit wlast_seen = 0;
   int last_b = -10, last_r = -10, beats = 0;
   bit e_awr = 0, e_wr = 0, e_bv = 0, e_arr = 0, e_rv = 0, e_rl = 0;
   int e_bid = 0, e_rid = 0;

   initial begin
      forever begin
         @(posedge clk_i);
         if (rst_i) begin
            aw_q.delete(); awt_q.delete();
            ar_id_q.delete(); ar_len_q.delete(); art_q.delete();
            wlast_seen = 0; beats = 0; last_b = -10; last_r = -10;
         end else begin
            if (e_bv && b_ready_i) begin
               void'(aw_q.pop_front()); void'(awt_q.pop_front());
               wlast_seen = 0; last_b = cyc;
            end
            if (e_wr && w_valid_i && w_last_i) wlast_seen = 1;
            if (e_awr && aw_valid_i) begin aw_q.push_back(int'(aw_id_i)); awt_q.push_back(cyc); end
            if (e_rv && r_ready_i) begin
               if (beats == ar_len_q[0]) begin
                  void'(ar_id_q.pop_front()); void'(ar_len_q.pop_front()); void'(art_q.pop_front());
                  beats = 0; last_r = cyc;
               end else beats++;
            end
            if (e_arr && ar_valid_i) begin
               ar_id_q.push_back(int'(ar_id_i)); ar_len_q.push_back(int'(ar_len_i)); art_q.push_back(cyc);
            end
         end
         cyc++;
         @(negedge clk_i);
         e_awr = !rst_i && aw_q.size() < MT;
         e_arr = !rst_i && ar_id_q.size() < MT;
         e_wr  = 0; e_bv = 0; e_rv = 0; e_rl = 0; e_bid = 0; e_rid = 0;
         if (!rst_i && aw_q.size() > 0) begin
            e_bid = aw_q[0];
            e_bv  = wlast_seen;
            e_wr  = !wlast_seen && cyc >= max2(awt_q[0] + 1, last_b + 2);
         end
         if (!rst_i && ar_id_q.size() > 0) begin
            e_rid = ar_id_q[0];
            e_rv  = cyc >= max2(art_q[0] + 1, last_r + 2);
            e_rl  = e_rv && beats == ar_len_q[0];
         end
         chk("aw_ready", 64'(aw_ready_o), 64'(e_awr));
         chk("w_ready",  64'(w_ready_o),  64'(e_wr));
         chk("b_valid",  64'(b_valid_o),  64'(e_bv));
         chk("ar_ready", 64'(ar_ready_o), 64'(e_arr));
         chk("r_valid",  64'(r_valid_o),  64'(e_rv));
         if (e_bv) begin
            chk("b_id", 64'(b_id_o), 64'(e_bid));
            chk("b_resp", 64'(b_resp_o), 64'(2'b11));
         end else if (!rst_i && !e_wr) chk("b_id_idle", 64'(b_id_o), 64'd0);
         if (e_rv) begin
            chk("r_id", 64'(r_id_o), 64'(e_rid));
            chk("r_data", r_data_o, EXP_DATA);
            chk("r_resp", 64'(r_resp_o), 64'(2'b11));
            chk("r_last", 64'(r_last_o), 64'(e_rl));
         end else if (!rst_i) begin
            chk("r_id_idle", 64'(r_id_o), 64'd0);
            chk("r_last_idle", 64'(r_last_o), 64'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   task automatic idle_in();
      aw_valid_i = 0; aw_id_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
      ar_valid_i = 0; ar_id_i = 0; ar_len_i = 0; r_ready_i = 1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int  nb;
      bit  done, aw_acc, rlast_seen;
      int  bids[$];
      int  r;

      idle_in();
      step();
      mid();
      chk("rst_aw_ready", 64'(aw_ready_o), 64'd0);
      chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
      chk("rst_b_valid",  64'(b_valid_o),  64'd0);
      chk("rst_r_valid",  64'(r_valid_o),  64'd0);
      chk("rst_w_ready",  64'(w_ready_o),  64'd0);
      step(); rst_i = 0;
      mid();
      chk("rst_b_id", 64'(b_id_o), 64'd0);
      chk("rst_r_last", 64'(r_last_o), 64'd0);

      // single write
      step(); aw_valid_i = 1; aw_id_i = 3; w_valid_i = 1; w_last_i = 1;
      mid(); chk("t1_aw_ready", 64'(aw_ready_o), 64'd1); chk("t1_w_ready_early", 64'(w_ready_o), 64'd0);
      step(); aw_valid_i = 0;
      mid(); chk("t1_w_ready", 64'(w_ready_o), 64'd1);
      step(); w_valid_i = 0; w_last_i = 0;
      mid(); chk("t1_b_valid", 64'(b_valid_o), 64'd1); chk("t1_b_id", 64'(b_id_o), 64'd3);
      chk("t1_b_resp", 64'(b_resp_o), 64'd3);
      step(); mid(); chk("t1_b_done", 64'(b_valid_o), 64'd0);

      // 4-beat read
      step(); ar_valid_i = 1; ar_id_i = 5; ar_len_i = 3;
      mid(); chk("t2_ar_ready", 64'(ar_ready_o), 64'd1);
      step(); ar_valid_i = 0;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("t2_r_valid", 64'(r_valid_o), 64'd1);
         chk("t2_r_id", 64'(r_id_o), 64'd5);
         chk("t2_r_data", r_data_o, 64'hCA11AB1EBADCAB1E);
         chk("t2_r_last", 64'(r_last_o), 64'(i == 3));
         step();
      end
      mid(); chk("t2_r_done", 64'(r_valid_o), 64'd0);

      // B backpressure, then R with toggling ready
      step(); aw_valid_i = 1; aw_id_i = 7; w_valid_i = 1; w_last_i = 1; b_ready_i = 0;
      step(); aw_valid_i = 0;
      step(); w_valid_i = 0; w_last_i = 0;
      for (int i = 0; i < 5; i++) begin
         mid(); chk("t3_b_hold", 64'(b_valid_o), 64'd1); chk("t3_b_id_hold", 64'(b_id_o), 64'd7);
         step();
      end
      b_ready_i = 1;
      mid(); chk("t3_b_valid", 64'(b_valid_o), 64'd1);
      step(); mid(); chk("t3_b_done", 64'(b_valid_o), 64'd0);
      step(); ar_valid_i = 1; ar_id_i = 2; ar_len_i = 4; r_ready_i = 0;
      step(); ar_valid_i = 0;
      nb = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         r_ready_i = 1'(i % 2);
         mid();
         if (r_valid_o && !r_ready_i) begin
            chk("t3_r_stall_id", 64'(r_id_o), 64'd2);
            chk("t3_r_stall_data", r_data_o, 64'hCA11AB1EBADCAB1E);
         end
         if (r_valid_o && r_ready_i) begin
            nb++;
            chk("t3_r_last", 64'(r_last_o), 64'(nb == 5));
            if (r_last_o) done = 1;
         end
         step();
      end
      chk("t3_beats", 64'(nb), 64'd5);
      idle_in(); idle(3);

      // AW FIFO full
      aw_valid_i = 1;
      for (int i = 0; i < 5; i++) begin
         aw_id_i = 4'(i);
         mid(); chk("t4_aw_ready", 64'(aw_ready_o), 64'(i < 4));
         if (i < 4) step();
      end
      step(); w_valid_i = 1; w_last_i = 1;
      aw_acc = 0; bids.delete();
      for (int i = 0; i < 60 && bids.size() < 5; i++) begin
         mid();
         if (b_valid_o && b_ready_i) bids.push_back(int'(b_id_o));
         if (aw_valid_i && aw_ready_o) aw_acc = 1;
         step();
         if (aw_acc) aw_valid_i = 0;
      end
      idle_in();
      chk("t4_aw5_accepted", 64'(aw_acc), 64'd1);
      chk("t4_nb", 64'(bids.size()), 64'd5);
      for (int k = 0; k < 5 && k < bids.size(); k++) chk("t4_b_order", 64'(bids[k]), 64'(k));
      idle(3);

      // early W plus a 256-beat read in parallel
      step(); ar_valid_i = 1; ar_id_i = 9; ar_len_i = 255; w_valid_i = 1; w_last_i = 1;
      nb = 0; rlast_seen = 0;
      for (int i = 0; i < 400 && !rlast_seen; i++) begin
         if (i == 1) ar_valid_i = 0;
         if (i == 3) begin aw_valid_i = 1; aw_id_i = 1; end
         if (i == 4) aw_valid_i = 0;
         if (i == 5) begin w_valid_i = 0; w_last_i = 0; end
         mid();
         if (i <= 3) chk("t5_early_w_blocked", 64'(w_ready_o), 64'd0);
         if (i == 4) chk("t5_w_ready", 64'(w_ready_o), 64'd1);
         if (i == 5) begin chk("t5_b_valid", 64'(b_valid_o), 64'd1); chk("t5_b_id", 64'(b_id_o), 64'd1); end
         if (i == 1) chk("t5_r_first", 64'(r_valid_o), 64'd1);
         if (r_valid_o && r_ready_i) begin
            nb++;
            if (r_last_o) begin rlast_seen = 1; chk("t5_last_at", 64'(nb), 64'd256); end
         end
         step();
      end
      chk("t5_beats", 64'(nb), 64'd256);
      idle_in(); idle(3);

      // reset in the middle of a burst
      step(); ar_valid_i = 1; ar_id_i = 4; ar_len_i = 7;
      step(); ar_valid_i = 0;
      mid(); chk("t6_beat1", 64'(r_valid_o), 64'd1);
      step(); rst_i = 1;
      mid(); chk("t6_r_in_rst", 64'(r_valid_o), 64'd0); chk("t6_ar_ready_in_rst", 64'(ar_ready_o), 64'd0);
      step(); rst_i = 0;
      mid(); chk("t6_r_after", 64'(r_valid_o), 64'd0); chk("t6_ar_empty", 64'(ar_ready_o), 64'd1);
      chk("t6_aw_empty", 64'(aw_ready_o), 64'd1);
      step(); mid(); chk("t6_no_resume", 64'(r_valid_o), 64'd0);
      step(); ar_valid_i = 1; ar_id_i = 6; ar_len_i = 0;
      step(); ar_valid_i = 0;
      mid(); chk("t6_r_valid", 64'(r_valid_o), 64'd1); chk("t6_r_last", 64'(r_last_o), 64'd1);
      chk("t6_r_id", 64'(r_id_o), 64'd6);
      step(); mid(); chk("t6_r_done", 64'(r_valid_o), 64'd0);

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_i      = ($urandom_range(0, 399) == 0);
         aw_valid_i = ($urandom_range(0, 2) == 0);
         aw_id_i    = 4'($urandom);
         w_valid_i  = 1'($urandom_range(0, 1));
         w_last_i   = ($urandom_range(0, 2) == 0);
         b_ready_i  = ($urandom_range(0, 3) != 0);
         ar_valid_i = ($urandom_range(0, 3) == 0);
         ar_id_i    = 4'($urandom);
         r = $urandom_range(0, 63);
         ar_len_i   = (r == 0) ? 8'd255 : (r < 48) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 15));
         r_ready_i  = ($urandom_range(0, 3) != 0);
      end
      step(); idle_in(); rst_i = 0;
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
